tcp_hdr_parser: RTL and testbench
=================================

// Module: tcp_hdr_parser
// PURPOSE
//  Inbound counterpart of the TX TCP header builder. Accepts a received tcp_pkt_hdr
//  struct with val/rdy and decodes it into per-field outputs in local orientation
//  (host_port = pkt dst_port, dest_port = pkt src_port). Also produces header length
//  and a packet-type class. Malformed headers are consumed and counted, never forwarded.
//  Sits between the IP RX path and the TCP slow-path state engine.
// PARAMETERS
//  FIFO_DEPTH  2   output buffer entries; only 2 is supported
//  DROP_CNT_W  32  width of the saturating drop counter
// PORTS
//  clk                    in   1          single clock, all logic on posedge
//  rst_n                  in   1          async assert, active-low reset; sync deassert from top
//  inbound_tcp_hdr_val    in   1          header valid
//  inbound_tcp_hdr        in   tcp_pkt_hdr  received TCP header struct
//  inbound_tcp_hdr_rdy    out  1          parser can accept
//  parsed_hdr_val         out  1          decoded header valid
//  parsed_hdr_rdy         in   1          consumer ready
//  parsed_host_port       out  PORT_NUM_W   = hdr.dst_port
//  parsed_dest_port       out  PORT_NUM_W   = hdr.src_port
//  parsed_seq_num         out  SEQ_NUM_W    = hdr.seq_num
//  parsed_ack_num         out  ACK_NUM_W    = hdr.ack_num
//  parsed_flags           out  FLAGS_W      = hdr.flags
//  parsed_win_size        out  WIN_SIZE_W   = hdr.win_size
//  parsed_hdr_len         out  6            raw_data_offset*4, in bytes
//  parsed_opt_len         out  6            parsed_hdr_len - TCP_HDR_BYTES
//  parsed_pkt_type        out  3            class, see BEHAVIOUR
//  drop_cnt               out  DROP_CNT_W   malformed headers dropped
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO count=0, read/write ptrs=0, entries=0, drop_cnt=0.
//    parsed_hdr_val=0, all parsed_* outputs=0, inbound_tcp_hdr_rdy=0 while in reset.
//    Reset mid-transfer discards all buffered headers; no partial output.
//  - Flag bits: FIN=0, SYN=1, RST=2, PSH=3, ACK=4.
//  - Handshake: an accept occurs when val&rdy on a clk edge.
//    inbound_tcp_hdr_rdy = (count != 2). It is a function of registered state only:
//    no combinational path from parsed_hdr_rdy.
//    A transfer occurs when parsed_hdr_val&parsed_hdr_rdy; parsed_hdr_val = (count != 0).
//  - Decode is combinational on the inbound struct and is written into the FIFO on the
//    accept edge. Latency: accept at edge N -> parsed_hdr_val high after edge N if the
//    FIFO was empty.
//  - FIFO order is strict: entries leave in accept order. Outputs are driven from the
//    head entry and are held stable while val=1 and rdy=0.
//  - Simultaneous push+pop: count unchanged. When count=2, rdy=0 and only a pop is
//    possible. A consumer that is always ready sustains 1 header/cycle.
//  - Malformed when any of the following holds:
//    raw_data_offset < 5, or SYN&FIN, or SYN&RST, or reserved != 0.
//    A malformed header is still accepted (rdy rules unchanged), is not written to the FIFO,
//    and drop_cnt increments by 1, saturating at all-ones.
//  - parsed_pkt_type, first match wins:
//    RST -> 4; SYN&ACK -> 1; SYN -> 0; FIN -> 3; ACK -> 2; otherwise -> 5.
//  - chksum and urg_pointer are ignored. Checksum is verified upstream.
// TESTING
//  1 Reset, then accept hdr {src=0x1234,dst=0x0050,seq=0x10,ack=0,flags=0x02,off=5}:
//    next cycle val=1, host_port=0x0050, dest_port=0x1234, type=0, hdr_len=20, opt_len=0.
//  2 flags=0x12, off=8 -> type=1, hdr_len=32, opt_len=12. flags=0x11 -> type=3.
//    flags=0x14 -> type=4.
//  3 Hold parsed_hdr_rdy=0 and offer 3 headers back-to-back:
//    first 2 accepted, rdy drops to 0 and the 3rd stalls.
//    Release rdy: outputs appear in order A, B, C with no loss or duplication.
//  4 Malformed cases off=4, flags=0x03, flags=0x06, reserved=1:
//    each accepted, no parsed_hdr_val, drop_cnt 0->4.
//    Preload drop_cnt near max: it saturates at 0xFFFFFFFF.
//  5 Consumer always ready, 100 back-to-back valid headers:
//    100 outputs in 100 consecutive cycles after the first; inbound rdy never falls.
//  6 Assert rst_n low with count=2 mid-stream:
//    val=0 and drop_cnt=0 immediately (async).
//    After release, the first new header is the first output.

Source files
------------

// File: rtl/tcp_hdr_parser.sv
// tcp_hdr_parser: decodes a received TCP header into local-orientation fields.
// Malformed headers are consumed and counted. Valid headers go into a 2-entry
// output FIFO and leave in the order they were accepted.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   inbound_tcp_hdr_val/_rdy/hdr     inbound header handshake and payload
//   parsed_hdr_val/_rdy              decoded-header handshake
//   parsed_*                         decoded fields of the FIFO head entry
//   drop_cnt                         saturating count of malformed headers

package tcp_hdr_pkg;

  localparam int unsigned PORT_NUM_W    = 16;
  localparam int unsigned SEQ_NUM_W     = 32;
  localparam int unsigned ACK_NUM_W     = 32;
  localparam int unsigned FLAGS_W       = 6;
  localparam int unsigned WIN_SIZE_W    = 16;
  localparam int unsigned TCP_HDR_BYTES = 20;

  localparam int unsigned FLAG_FIN = 0;
  localparam int unsigned FLAG_SYN = 1;
  localparam int unsigned FLAG_RST = 2;
  localparam int unsigned FLAG_PSH = 3;
  localparam int unsigned FLAG_ACK = 4;

  // Received header, wire order
  typedef struct packed {
    logic [PORT_NUM_W-1:0] src_port;
    logic [PORT_NUM_W-1:0] dst_port;
    logic [SEQ_NUM_W-1:0]  seq_num;
    logic [ACK_NUM_W-1:0]  ack_num;
    logic [3:0]            raw_data_offset;
    logic [5:0]            reserved;
    logic [FLAGS_W-1:0]    flags;
    logic [WIN_SIZE_W-1:0] win_size;
    logic [15:0]           chksum;
    logic [15:0]           urg_pointer;
  } tcp_pkt_hdr;

  // Decoded header as stored in the output FIFO
  typedef struct packed {
    logic [PORT_NUM_W-1:0] host_port;
    logic [PORT_NUM_W-1:0] dest_port;
    logic [SEQ_NUM_W-1:0]  seq_num;
    logic [ACK_NUM_W-1:0]  ack_num;
    logic [FLAGS_W-1:0]    flags;
    logic [WIN_SIZE_W-1:0] win_size;
    logic [5:0]            hdr_len;
    logic [5:0]            opt_len;
    logic [2:0]            pkt_type;
  } parsed_hdr_t;

endpackage

module tcp_hdr_parser
  import tcp_hdr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DROP_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inbound_tcp_hdr_val,
  input  tcp_pkt_hdr            inbound_tcp_hdr,
  output logic                  inbound_tcp_hdr_rdy,
  output logic                  parsed_hdr_val,
  input  logic                  parsed_hdr_rdy,
  output logic [PORT_NUM_W-1:0] parsed_host_port,
  output logic [PORT_NUM_W-1:0] parsed_dest_port,
  output logic [SEQ_NUM_W-1:0]  parsed_seq_num,
  output logic [ACK_NUM_W-1:0]  parsed_ack_num,
  output logic [FLAGS_W-1:0]    parsed_flags,
  output logic [WIN_SIZE_W-1:0] parsed_win_size,
  output logic [5:0]            parsed_hdr_len,
  output logic [5:0]            parsed_opt_len,
  output logic [2:0]            parsed_pkt_type,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  parsed_hdr_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  rdy_q;
  logic                  val_q;

  parsed_hdr_t           dec_c;
  logic                  malformed_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  unused_c;

  // Checksum is verified upstream and urgent data is not handled here
  assign unused_c = ^{inbound_tcp_hdr.chksum, inbound_tcp_hdr.urg_pointer};

  // Combinational decode of the inbound header
  always_comb begin
    dec_c           = '0;
    dec_c.host_port = inbound_tcp_hdr.dst_port;
    dec_c.dest_port = inbound_tcp_hdr.src_port;
    dec_c.seq_num   = inbound_tcp_hdr.seq_num;
    dec_c.ack_num   = inbound_tcp_hdr.ack_num;
    dec_c.flags     = inbound_tcp_hdr.flags;
    dec_c.win_size  = inbound_tcp_hdr.win_size;
    dec_c.hdr_len   = {inbound_tcp_hdr.raw_data_offset, 2'b00};
    dec_c.opt_len   = dec_c.hdr_len - 6'(TCP_HDR_BYTES);
    // Class priority: RST, SYN+ACK, SYN, FIN, ACK, other
    if (inbound_tcp_hdr.flags[FLAG_RST])
      dec_c.pkt_type = 3'd4;
    else if (inbound_tcp_hdr.flags[FLAG_SYN] && inbound_tcp_hdr.flags[FLAG_ACK])
      dec_c.pkt_type = 3'd1;
    else if (inbound_tcp_hdr.flags[FLAG_SYN])
      dec_c.pkt_type = 3'd0;
    else if (inbound_tcp_hdr.flags[FLAG_FIN])
      dec_c.pkt_type = 3'd3;
    else if (inbound_tcp_hdr.flags[FLAG_ACK])
      dec_c.pkt_type = 3'd2;
    else
      dec_c.pkt_type = 3'd5;
  end

  // Malformed headers are consumed but never reach the FIFO
  always_comb begin
    malformed_c = 1'b0;
    if (inbound_tcp_hdr.raw_data_offset < 4'd5)
      malformed_c = 1'b1;
    if (inbound_tcp_hdr.flags[FLAG_SYN] && inbound_tcp_hdr.flags[FLAG_FIN])
      malformed_c = 1'b1;
    if (inbound_tcp_hdr.flags[FLAG_SYN] && inbound_tcp_hdr.flags[FLAG_RST])
      malformed_c = 1'b1;
    if (inbound_tcp_hdr.reserved != 6'd0)
      malformed_c = 1'b1;
  end

  assign accept_c = inbound_tcp_hdr_val & rdy_q;
  assign push_c   = accept_c & ~malformed_c;
  assign pop_c    = val_q & parsed_hdr_rdy;

  // Occupancy; push and pop together leave it unchanged
  always_comb begin
    count_next = count;
    if (push_c && !pop_c)
      count_next = count + CNT_W'(1);
    else if (pop_c && !push_c)
      count_next = count - CNT_W'(1);
  end

  // FIFO state plus handshake flags registered from the next occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
      val_q  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++)
        mem[i] <= '0;
    end else begin
      count <= count_next;
      rdy_q <= (count_next != CNT_W'(FIFO_DEPTH));
      val_q <= (count_next != CNT_W'(0));
      if (push_c) begin
        mem[wr_ptr] <= dec_c;
        wr_ptr      <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_c)
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // Saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (accept_c && malformed_c && (drop_cnt != {DROP_CNT_W{1'b1}}))
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  end

  assign inbound_tcp_hdr_rdy = rdy_q;
  assign parsed_hdr_val      = val_q;

  // Outputs come straight from the head entry register
  assign parsed_host_port = mem[rd_ptr].host_port;
  assign parsed_dest_port = mem[rd_ptr].dest_port;
  assign parsed_seq_num   = mem[rd_ptr].seq_num;
  assign parsed_ack_num   = mem[rd_ptr].ack_num;
  assign parsed_flags     = mem[rd_ptr].flags;
  assign parsed_win_size  = mem[rd_ptr].win_size;
  assign parsed_hdr_len   = mem[rd_ptr].hdr_len;
  assign parsed_opt_len   = mem[rd_ptr].opt_len;
  assign parsed_pkt_type  = mem[rd_ptr].pkt_type;

endmodule

// File: tb/tb_tcp_hdr_parser.sv
// tb_tcp_hdr_parser: directed bench for tcp_hdr_parser with hand-computed
// expected values. A second instance with a 3-bit drop counter exercises
// counter saturation.
module tb_tcp_hdr_parser;
  import tcp_hdr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_val = 1'b0;
  tcp_pkt_hdr  in_hdr = '0;
  logic        in_rdy;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic [15:0] out_host, out_dest;
  logic [31:0] out_seq, out_ack;
  logic [5:0]  out_flags;
  logic [15:0] out_win;
  logic [5:0]  out_hlen, out_olen;
  logic [2:0]  out_type;
  logic [31:0] drop;

  // Small-counter instance signals
  logic        s_val = 1'b0;
  tcp_pkt_hdr  s_hdr = '0;
  logic        s_in_rdy, s_out_val;
  logic        s_out_rdy = 1'b1;
  logic [15:0] s_host, s_dest;
  logic [31:0] s_seq, s_ack;
  logic [5:0]  s_flags;
  logic [15:0] s_win;
  logic [5:0]  s_hlen, s_olen;
  logic [2:0]  s_type;
  logic [2:0]  s_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tcp_hdr_parser #(.FIFO_DEPTH(2), .DROP_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inbound_tcp_hdr_val(in_val), .inbound_tcp_hdr(in_hdr), .inbound_tcp_hdr_rdy(in_rdy),
    .parsed_hdr_val(out_val), .parsed_hdr_rdy(out_rdy),
    .parsed_host_port(out_host), .parsed_dest_port(out_dest),
    .parsed_seq_num(out_seq), .parsed_ack_num(out_ack),
    .parsed_flags(out_flags), .parsed_win_size(out_win),
    .parsed_hdr_len(out_hlen), .parsed_opt_len(out_olen),
    .parsed_pkt_type(out_type), .drop_cnt(drop)
  );

  tcp_hdr_parser #(.FIFO_DEPTH(2), .DROP_CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .inbound_tcp_hdr_val(s_val), .inbound_tcp_hdr(s_hdr), .inbound_tcp_hdr_rdy(s_in_rdy),
    .parsed_hdr_val(s_out_val), .parsed_hdr_rdy(s_out_rdy),
    .parsed_host_port(s_host), .parsed_dest_port(s_dest),
    .parsed_seq_num(s_seq), .parsed_ack_num(s_ack),
    .parsed_flags(s_flags), .parsed_win_size(s_win),
    .parsed_hdr_len(s_hlen), .parsed_opt_len(s_olen),
    .parsed_pkt_type(s_type), .drop_cnt(s_drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic tcp_pkt_hdr mk(input logic [15:0] src, input logic [15:0] dst,
                                    input logic [31:0] seq, input logic [5:0] flags,
                                    input logic [3:0] off, input logic [5:0] res);
    tcp_pkt_hdr h;
    h                 = '0;
    h.src_port        = src;
    h.dst_port        = dst;
    h.seq_num         = seq;
    h.ack_num         = 32'h0;
    h.raw_data_offset = off;
    h.reserved        = res;
    h.flags           = flags;
    h.win_size        = 16'h2000;
    h.chksum          = 16'hBEEF;
    h.urg_pointer     = 16'h0101;
    return h;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push_hdr(input tcp_pkt_hdr h);
    int n;
    n      = 0;
    in_hdr = h;
    in_val = 1'b1;
    while (!in_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("push_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_val = 1'b0;
  endtask

  task automatic pop_one();
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic        rdy_now;
    int          sent, first, last, order_bad;
    bit          rdy_fell;

    // Reset state
    #12;
    chk("rst_val", 64'(out_val), 64'd0);
    chk("rst_rdy", 64'(in_rdy), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_seq", 64'(out_seq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 64'(in_rdy), 64'd1);

    // Basic SYN header
    push_hdr(mk(16'h1234, 16'h0050, 32'h10, 6'h02, 4'd5, 6'd0));
    chk("t1_val", 64'(out_val), 64'd1);
    chk("t1_host", 64'(out_host), 64'h0050);
    chk("t1_dest", 64'(out_dest), 64'h1234);
    chk("t1_seq", 64'(out_seq), 64'h10);
    chk("t1_ack", 64'(out_ack), 64'h0);
    chk("t1_win", 64'(out_win), 64'h2000);
    chk("t1_flags", 64'(out_flags), 64'h02);
    chk("t1_type", 64'(out_type), 64'd0);
    chk("t1_hlen", 64'(out_hlen), 64'd20);
    chk("t1_olen", 64'(out_olen), 64'd0);
    pop_one();
    chk("t1_empty", 64'(out_val), 64'd0);

    // Packet classes and option length
    push_hdr(mk(16'h1, 16'h2, 32'h20, 6'h12, 4'd8, 6'd0));
    chk("t2_synack_type", 64'(out_type), 64'd1);
    chk("t2_hlen", 64'(out_hlen), 64'd32);
    chk("t2_olen", 64'(out_olen), 64'd12);
    pop_one();
    push_hdr(mk(16'h1, 16'h2, 32'h21, 6'h11, 4'd5, 6'd0));
    chk("t2_fin_type", 64'(out_type), 64'd3);
    pop_one();
    push_hdr(mk(16'h1, 16'h2, 32'h22, 6'h14, 4'd15, 6'd0));
    chk("t2_rst_type", 64'(out_type), 64'd4);
    chk("t2_hlen60", 64'(out_hlen), 64'd60);
    chk("t2_olen40", 64'(out_olen), 64'd40);
    pop_one();
    push_hdr(mk(16'h1, 16'h2, 32'h23, 6'h10, 4'd5, 6'd0));
    chk("t2_ack_type", 64'(out_type), 64'd2);
    pop_one();
    push_hdr(mk(16'h1, 16'h2, 32'h24, 6'h08, 4'd5, 6'd0));
    chk("t2_other_type", 64'(out_type), 64'd5);
    pop_one();

    // Backpressure: A, B fill the FIFO, C stalls
    in_val = 1'b1;
    in_hdr = mk(16'h1, 16'h2, 32'hA, 6'h10, 4'd5, 6'd0);
    @(negedge clk);
    chk("t3_rdy_one", 64'(in_rdy), 64'd1);
    in_hdr = mk(16'h1, 16'h2, 32'hB, 6'h10, 4'd5, 6'd0);
    @(negedge clk);
    chk("t3_rdy_full", 64'(in_rdy), 64'd0);
    in_hdr = mk(16'h1, 16'h2, 32'hC, 6'h10, 4'd5, 6'd0);
    @(negedge clk);
    chk("t3_rdy_stall", 64'(in_rdy), 64'd0);
    chk("t3_head_held", 64'(out_seq), 64'hA);
    out_rdy = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_val) q.push_back(out_seq);
      rdy_now = in_rdy;
      @(negedge clk);
      if (in_val && rdy_now) in_val = 1'b0;
    end
    out_rdy = 1'b0;
    chk("t3_count", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      chk("t3_ord0", 64'(q[0]), 64'hA);
      chk("t3_ord1", 64'(q[1]), 64'hB);
      chk("t3_ord2", 64'(q[2]), 64'hC);
    end
    q.delete();

    // Malformed headers
    push_hdr(mk(16'h1, 16'h2, 32'h40, 6'h10, 4'd4, 6'd0));
    chk("t4_off4_val", 64'(out_val), 64'd0);
    push_hdr(mk(16'h1, 16'h2, 32'h41, 6'h03, 4'd5, 6'd0));
    chk("t4_synfin_val", 64'(out_val), 64'd0);
    push_hdr(mk(16'h1, 16'h2, 32'h42, 6'h06, 4'd5, 6'd0));
    chk("t4_synrst_val", 64'(out_val), 64'd0);
    push_hdr(mk(16'h1, 16'h2, 32'h43, 6'h10, 4'd5, 6'd1));
    chk("t4_res_val", 64'(out_val), 64'd0);
    chk("t4_drop4", 64'(drop), 64'd4);

    // Saturation on the 3-bit counter instance
    s_hdr = mk(16'h1, 16'h2, 32'h50, 6'h10, 4'd0, 6'd0);
    s_val = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_sat_5", 64'(s_drop), 64'd5);
    repeat (2) @(negedge clk);
    chk("t4_sat_7", 64'(s_drop), 64'd7);
    repeat (2) @(negedge clk);
    s_val = 1'b0;
    chk("t4_sat_hold", 64'(s_drop), 64'd7);
    chk("t4_sat_noval", 64'(s_out_val), 64'd0);

    // Streaming with an always-ready consumer
    out_rdy   = 1'b1;
    sent      = 0;
    first     = -1;
    last      = -1;
    rdy_fell  = 1'b0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      @(negedge clk);
      if (in_val) sent++;
      if (out_val) begin
        q.push_back(out_seq);
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (!in_rdy) rdy_fell = 1'b1;
      if (sent < 100) begin
        in_val = 1'b1;
        in_hdr = mk(16'h7, 16'h8, 32'(sent), 6'h10, 4'd5, 6'd0);
      end else begin
        in_val = 1'b0;
      end
    end
    out_rdy = 1'b0;
    chk("t5_rdy_never_fell", 64'(rdy_fell), 64'd0);
    chk("t5_count", 64'(q.size()), 64'd100);
    chk("t5_span", 64'(last - first), 64'd99);
    order_bad = 0;
    foreach (q[i]) if (q[i] != 32'(i)) order_bad++;
    chk("t5_order", 64'(order_bad), 64'd0);
    q.delete();
    chk("t5_drop_unchanged", 64'(drop), 64'd4);

    // Async reset with a full FIFO
    push_hdr(mk(16'h1, 16'h2, 32'h60, 6'h10, 4'd5, 6'd0));
    push_hdr(mk(16'h1, 16'h2, 32'h61, 6'h10, 4'd5, 6'd0));
    chk("t6_full_rdy", 64'(in_rdy), 64'd0);
    chk("t6_full_val", 64'(out_val), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_val", 64'(out_val), 64'd0);
    chk("t6_rst_drop", 64'(drop), 64'd0);
    chk("t6_rst_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_hdr(mk(16'h1, 16'h2, 32'hD00D, 6'h10, 4'd5, 6'd0));
    chk("t6_new_val", 64'(out_val), 64'd1);
    chk("t6_new_seq", 64'(out_seq), 64'hD00D);
    pop_one();
    chk("t6_drained", 64'(out_val), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
